// File: rtl/cont_sequenciador.sv
// cont_sequenciador: run controller for the auto-counter display path.
// Conditions start/pause/clear switch levels into edge commands, prescales
// the board clock into a count tick and sequences a 2-digit BCD count
// through IDLE/RUN/PAUSE/DONE.
// Build option: define CONT_AUTO_RELOAD_EN to wrap LIMIT -> 00 and stay in
// RUN (done becomes a one-cycle pulse) instead of stopping in DONE.
module cont_sequenciador #(
  parameter int DIV   = 50000000,  // clock cycles per count tick (>=2)
  parameter int LIMIT = 59         // terminal count, decimal 1..99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  output logic [7:0] count_bcd,
  output logic       tick,
  output logic       running,
  output logic       done,
  output logic [1:0] estado
);

  localparam int             PW        = $clog2(DIV);
  localparam logic [PW-1:0]  PRE_MAX   = PW'(DIV - 1);
  localparam logic [7:0]     LIMIT_BCD = {4'(LIMIT / 10), 4'(LIMIT % 10)};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // bit order in the conditioning pipes: {clear, pause, start}
  logic [2:0] sync1, sync2, prev;
  logic [2:0] cmd;
  logic       cmd_start, cmd_pause, cmd_clear;

  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n, cnt_inc;
  logic [PW-1:0] pre, pre_n;
  logic          tick_n, done_n;
  logic          wrap;

  // one BCD step: units roll into tens, tens saturate-wrap at 9
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  // two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {btn_clear, btn_pause, btn_start};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // a command is the rising edge of the synchronized level only
  assign cmd       = sync2 & ~prev;
  assign cmd_start = cmd[0];
  assign cmd_pause = cmd[1];
  assign cmd_clear = cmd[2];

  assign wrap    = (pre == PRE_MAX);
  assign cnt_inc = bcd_inc(cnt);

  // next-state, prescaler and count; clear > pause > start
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pre_n   = pre;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    if (cmd_clear) begin
      state_n = IDLE;
      cnt_n   = 8'h00;
      pre_n   = '0;
    end else begin
      case (state)
        IDLE: if (cmd_start) begin
          state_n = RUN;
          pre_n   = '0;
        end
        RUN: begin
          if (cmd_pause) begin
            // pause wins over a coincident wrap: prescaler and count hold
            state_n = PAUSE;
          end else if (wrap) begin
            pre_n  = '0;
            tick_n = 1'b1;
`ifdef CONT_AUTO_RELOAD_EN
            if (cnt == LIMIT_BCD) begin
              cnt_n  = 8'h00;
              done_n = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
`else
            cnt_n = cnt_inc;
            if (cnt_inc == LIMIT_BCD) state_n = DONE;
`endif
          end else begin
            pre_n = pre + PW'(1);
          end
        end
        PAUSE: if (cmd_pause || cmd_start) state_n = RUN;
        DONE: if (cmd_start) begin
          state_n = RUN;
          cnt_n   = 8'h00;
          pre_n   = '0;
        end
        default: state_n = IDLE;
      endcase
    end
`ifndef CONT_AUTO_RELOAD_EN
    // done is a level tracking the DONE state
    done_n = (state_n == DONE);
`endif
  end

  // state, count, prescaler and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'h00;
      pre   <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pre   <= pre_n;
      tick  <= tick_n;
      done  <= done_n;
    end
  end

  assign count_bcd = cnt;
  assign estado    = state;
  assign running   = (state == RUN);

endmodule

// File: tb/tb_cont_sequenciador.sv
// tb_cont_sequenciador: scoreboard bench for cont_sequenciador (DIV=4, LIMIT=12).
// Stimulus pushes expected ticks into a queue; a monitor pops one per tick.
module tb_cont_sequenciador;
  localparam int DIV   = 4;
  localparam int LIMIT = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] count_bcd;
  logic       tick, running, done;
  logic [1:0] estado;

  cont_sequenciador #(.DIV(DIV), .LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .count_bcd(count_bcd), .tick(tick), .running(running),
    .done(done), .estado(estado)
  );

  always #5 clock = ~clock;

  // posedge counter used to time ticks
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] cnt;
    logic       dn;
    logic [1:0] st;
    int         gap;  // cycles since previous tick, 0 = unchecked
    int         at;   // absolute cycle of the tick, 0 = unchecked
  } exp_t;

  exp_t q[$];

  int d_cmp = 0, d_bad = 0;  // stimulus-side checks
  int m_cmp = 0, m_bad = 0;  // monitor-side checks

  // hand-written expected count sequence for LIMIT=12
  logic [7:0] seq [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h00, 8'h01};

  function automatic int miss(string nm, logic [31:0] a, logic [31:0] e);
    if (a !== e) begin
      $display("FAIL %s: got %0h, want %0h", nm, a, e);
      return 1;
    end
    return 0;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    d_cmp++;
    d_bad += miss(nm, a, e);
  endtask

  task automatic at_neg(int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic push(logic [7:0] c, logic dn, logic [1:0] st, int gap, int at);
    exp_t e;
    e.cnt = c; e.dn = dn; e.st = st; e.gap = gap; e.at = at;
    q.push_back(e);
  endtask

  task automatic drain(string nm, int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      at_neg();
      k++;
    end
    d_cmp++;
    if (q.size() != 0) begin
      d_bad++;
      $display("FAIL %s: %0d ticks outstanding after %0d cycles, want 0", nm, q.size(), budget);
      q.delete();
    end
  endtask

  // monitor: every tick must match the head of the scoreboard
  initial begin
    exp_t me;
    int   last_tick = 0;
    forever begin
      @(negedge clock);
      if (!reset && tick) begin
        if (q.size() == 0) begin
          m_cmp++;
          m_bad++;
          $display("FAIL unexpected_tick: tick with count %h, want no tick", count_bcd);
        end else begin
          me = q.pop_front();
          m_cmp++; m_bad += miss("tick_count", count_bcd, me.cnt);
          m_cmp++; m_bad += miss("tick_done", done, me.dn);
          m_cmp++; m_bad += miss("tick_estado", estado, me.st);
          if (me.gap != 0) begin
            m_cmp++; m_bad += miss("tick_gap", cyc - last_tick, me.gap);
          end
          if (me.at != 0) begin
            m_cmp++; m_bad += miss("tick_time", cyc, me.at);
          end
        end
        last_tick = cyc;
      end
`ifdef CONT_AUTO_RELOAD_EN
      if (!reset && done && !tick) begin
        m_cmp++;
        m_bad++;
        $display("FAIL done_pulse: done=1 without tick at count %h, want done only with tick", count_bcd);
      end
`endif
    end
  end

  initial begin
    int n;
    // reset state
    at_neg(2);
    chk("rst_count", count_bcd, 8'h00);
    chk("rst_estado", estado, 2'b00);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tick", tick, 1'b0);
    reset = 1'b0;
    at_neg();

    // run to 07, then asynchronous reset between edges
    n = cyc;
    for (int i = 0; i < 7; i++) push(seq[i], 1'b0, 2'b01, (i == 0) ? 0 : 4, (i == 0) ? n + 7 : 0);
    btn_start = 1'b1;
    at_neg(3);
    btn_start = 1'b0;
    drain("run_to_07", 200);
    chk("pre_reset_count", count_bcd, 8'h07);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", count_bcd, 8'h00);
    chk("async_rst_estado", estado, 2'b00);
    chk("async_rst_running", running, 1'b0);
    chk("async_rst_done", done, 1'b0);
    reset = 1'b0;
    at_neg();

    // start, run to 05, pause with prescaler at 2
    n = cyc;
    for (int i = 0; i < 5; i++) push(seq[i], 1'b0, 2'b01, (i == 0) ? 0 : 4, (i == 0) ? n + 7 : 0);
    btn_start = 1'b1;
    at_neg(3);
    btn_start = 1'b0;
    drain("run_to_05", 200);
    btn_pause = 1'b1;
    at_neg(3);
    btn_pause = 1'b0;
    at_neg(17);
    chk("pause_estado", estado, 2'b10);
    chk("pause_count", count_bcd, 8'h05);
    chk("pause_running", running, 1'b0);

    // resume: prescaler held at 2, tick 2 cycles after RUN
    n = cyc;
    push(8'h06, 1'b0, 2'b01, 0, n + 5);
    btn_pause = 1'b1;
    at_neg(3);
    chk("resume_estado", estado, 2'b01);
    btn_pause = 1'b0;
    drain("resume", 50);

    // pause and clear together: clear wins
    btn_pause = 1'b1;
    btn_clear = 1'b1;
    at_neg(3);
    chk("clr_prio_estado", estado, 2'b00);
    chk("clr_prio_count", count_bcd, 8'h00);
    btn_pause = 1'b0;
    btn_clear = 1'b0;
    at_neg();

    // start held high: one command, counts through the terminal value
    n = cyc;
`ifdef CONT_AUTO_RELOAD_EN
    for (int i = 0; i < 14; i++)
      push(seq[i], (i == 12), 2'b01, (i == 0) ? 0 : 4, (i == 0) ? n + 7 : 0);
`else
    for (int i = 0; i < 12; i++)
      push(seq[i], (i == 11), (i == 11) ? 2'b11 : 2'b01, (i == 0) ? 0 : 4, (i == 0) ? n + 7 : 0);
`endif
    btn_start = 1'b1;
    at_neg(50);
    btn_start = 1'b0;
    drain("held_start_run", 200);

`ifdef CONT_AUTO_RELOAD_EN
    chk("reload_estado", estado, 2'b01);
    chk("reload_done_low", done, 1'b0);
    chk("reload_running", running, 1'b1);
`else
    at_neg(10);
    chk("done_estado", estado, 2'b11);
    chk("done_level", done, 1'b1);
    chk("done_running", running, 1'b0);
    chk("done_count_hold", count_bcd, 8'h12);

    // restart from DONE
    n = cyc;
    push(8'h01, 1'b0, 2'b01, 0, n + 7);
    btn_start = 1'b1;
    at_neg(3);
    chk("restart_count", count_bcd, 8'h00);
    chk("restart_estado", estado, 2'b01);
    chk("restart_done", done, 1'b0);
    btn_start = 1'b0;
    drain("restart", 50);
`endif

    // final clear
    btn_clear = 1'b1;
    at_neg(3);
    btn_clear = 1'b0;
    chk("final_estado", estado, 2'b00);
    chk("final_count", count_bcd, 8'h00);
    at_neg(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", d_cmp + m_cmp, d_bad + m_bad);
    $finish;
  end

endmodule
